store_rmw_unit: RTL and testbench
=================================

# store_rmw_unit

Write-side counterpart to the core's sub-word load path: accepts sb/sh/sw store requests and applies them to a word-wide data memory that has no byte enables, using a read-modify-write sequence. Sits between the RISC-V datapath (store address from the ALU, store data from rs2) and the data memory write port. Little-endian lane placement mirrors the lb/lh/lhu extraction on the load side.

## Interface
- No parameters; address and data widths are fixed at 32.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  store request present
- req_ready  out  1  unit can accept a request
- req_addr  in  32  byte address of the store
- req_data  in  32  store data (rs2); low byte/half used for sb/sh
- req_size  in  2  mem_size_e: SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10 (funct3[1:0])
- mem_addr  out  32  word-aligned byte address, bits [1:0] always 0
- mem_rd_data  in  32  memory read data, valid one cycle after mem_addr is driven
- mem_wd_data  out  32  merged write word
- mem_we  out  1  memory write strobe
- done  out  1  one-cycle pulse: request retired
- err  out  1  one-cycle pulse with done: misaligned request, no write

## Operation
- States: IDLE, RD, WR.
- IDLE: req_ready=1. On req_valid&&req_ready, latch addr/data/size; next state RD (aligned) or WR (misaligned, error path).
- RD: mem_addr={addr[31:2],2'b00}, mem_we=0; memory registers read data.
- WR: mem_wd_data = merge(mem_rd_data); mem_we=1; done=1; next state IDLE.
- Merge: SZ_B replaces bits [8*addr[1:0] +: 8] with data[7:0]; SZ_H replaces [16*addr[1] +: 16] with data[15:0]; SZ_W replaces all 32 bits. Unaffected lanes retain mem_rd_data.
- Misaligned: SZ_H with addr[0]=1, SZ_W with addr[1:0]!=0, or req_size=2'b11. Goes IDLE->WR with mem_we=0, done=1, err=1. Memory untouched.
- Requests accepted only in IDLE; req_valid in RD/WR is ignored (req_ready=0).
- Reset mid-operation: state forced to IDLE immediately; latched request dropped; no write issued.

## Timing
- Reset values: state IDLE, mem_we=0, done=0, err=0, mem_addr=0, mem_wd_data=0, latched request 0. req_ready=(state==IDLE)&&!rst, so 0 while rst is high.
- sb/sh (and sw without macro): accept edge T; RD in cycle T+1; WR (mem_we, done) in cycle T+2; req_ready high again in T+3. Throughput one store per 3 cycles.
- Misaligned: done/err in cycle T+1; req_ready in T+2.
- mem_we, done and err are registered-state decodes: glitch-free, exactly one cycle wide.
- Back-to-back stores to the same word: the second store's RD follows the first's WR, so it reads the updated word (no forwarding needed).

## Configuration
- STORE_RMW_WORD_BYPASS_EN defined: aligned SZ_W skips RD (IDLE->WR), mem_wd_data=req_data, done in T+1, 2-cycle throughput.
- Undefined: SZ_W takes the full RD->WR path like sb/sh, with an identical written value.

## Structure
- mem_size_e typedef and the state enum go in shared header riscv/mem.svh, next to the existing datapath enums; the load-side extractor reuses mem_size_e.
- Sub-module store_merge: purely combinational (old word, data, addr[1:0], size) -> new word, plus misalign flag; the FSM lives in store_rmw_unit.

## Test plan
- mem[2]=0xdeadbeef; sb addr 0x9 data 0x000000aa -> RD addr 0x8, WR cycle T+2 with mem_wd_data=0xdeadaaef, mem_we=1, done=1, err=0.
- mem[2]=0xdeadbeef; sh addr 0xa data 0x00001234 -> mem[2]=0x1234beef; sh addr 0x8 data 0xc0de -> 0x1234c0de.
- sw addr 0x8 data 0xc001c0de -> mem[2]=0xc001c0de; done at T+2 without macro, T+1 with STORE_RMW_WORD_BYPASS_EN and no RD cycle.
- sh addr 0x9 -> done=1, err=1 at T+1, mem_we never asserted, mem[2] unchanged; sw addr 0xa same.
- rst pulsed during RD of sb addr 0x8 -> no mem_we, done stays 0, req_ready=1 the cycle after rst drops, mem unchanged.
- req_valid held high: sb 0x8 data 0x11, then sb 0xb data 0x22 on mem[2]=0xdeadbeef -> writes 0xdeadbe11 then 0x22adbe11; second accept one cycle after first done.

Source files
------------

// File: rtl/store_rmw_unit_pkg.sv
// Shared types for the store read-modify-write unit: access size encoding,
// FSM states and the sub-word alignment rule.
package store_rmw_unit_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10
    } rmw_state_e;

    // Halves must sit on even bytes, words on word boundaries; 2'b11 is never legal.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = addr_lo[0];
            SZ_W:    mis = (addr_lo != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/store_rmw_unit_merge.sv
// store_merge: combinational little-endian lane insert of store data into the
// old memory word, plus the misalignment flag for the same request.
module store_merge
    import store_rmw_unit_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] data,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    output logic [31:0] new_word,
    output logic        misaligned
);

    // Replace only the addressed lane; everything else keeps the old word.
    always_comb begin
        new_word = old_word;
        case (size)
            SZ_B:    new_word[{addr_lo, 3'b000} +: 8]     = data[7:0];
            SZ_H:    new_word[{addr_lo[1], 4'b0000} +: 16] = data[15:0];
            SZ_W:    new_word                              = data;
            default: new_word                              = old_word;
        endcase
    end

    assign misaligned = is_misaligned(size, addr_lo);

endmodule

// File: rtl/store_rmw_unit.sv
// store_rmw_unit: sb/sh/sw via read-modify-write on a word memory without byte
// enables. Optional macro STORE_RMW_WORD_BYPASS_EN lets aligned sw skip the read.
module store_rmw_unit
    import store_rmw_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [1:0]  req_size,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rd_data,
    output logic [31:0] mem_wd_data,
    output logic        mem_we,
    output logic        done,
    output logic        err
);

    rmw_state_e  state_r, state_nxt_s;
    logic [31:0] addr_r, data_r;
    logic [1:0]  size_r;
    logic        mem_we_r, done_r, err_r;
    logic        we_nxt_s, done_nxt_s, err_nxt_s, accept_s;
    logic        req_mis_s, bypass_s, mrg_mis_s;
    logic [31:0] merged_s;

    assign req_mis_s = is_misaligned(req_size, req_addr[1:0]);

`ifdef STORE_RMW_WORD_BYPASS_EN
    assign bypass_s = (req_size == SZ_W);
`else
    assign bypass_s = 1'b0;
`endif

    store_merge u_merge (
        .old_word   (mem_rd_data),
        .data       (data_r),
        .addr_lo    (addr_r[1:0]),
        .size       (size_r),
        .new_word   (merged_s),
        .misaligned (mrg_mis_s)
    );

    // Next state plus next values of the registered strobes, so the strobes
    // are flop outputs aligned exactly with the WR state.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        we_nxt_s    = 1'b0;
        done_nxt_s  = 1'b0;
        err_nxt_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    accept_s = 1'b1;
                    if (req_mis_s) begin
                        state_nxt_s = ST_WR;
                        done_nxt_s  = 1'b1;
                        err_nxt_s   = 1'b1;
                    end else if (bypass_s) begin
                        state_nxt_s = ST_WR;
                        done_nxt_s  = 1'b1;
                        we_nxt_s    = 1'b1;
                    end else begin
                        state_nxt_s = ST_RD;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RD: begin
                state_nxt_s = ST_WR;
                done_nxt_s  = 1'b1;
                we_nxt_s    = !mrg_mis_s;
                err_nxt_s   = mrg_mis_s;
            end
            ST_WR:   state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, strobes and the latched request; reset drops any store in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            mem_we_r <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            addr_r   <= 32'h0000_0000;
            data_r   <= 32'h0000_0000;
            size_r   <= 2'b00;
        end else begin
            state_r  <= state_nxt_s;
            mem_we_r <= we_nxt_s;
            done_r   <= done_nxt_s;
            err_r    <= err_nxt_s;
            if (accept_s) begin
                addr_r <= req_addr;
                data_r <= req_data;
                size_r <= req_size;
            end
        end
    end

    assign req_ready   = (state_r == ST_IDLE) && !rst;
    assign mem_addr    = {addr_r[31:2], 2'b00};
    // Read data only arrives in WR, so the merge result cannot be registered.
    assign mem_wd_data = mem_we_r ? merged_s : 32'h0000_0000;
    assign mem_we      = mem_we_r;
    assign done        = done_r;
    assign err         = err_r;

endmodule

// File: tb/tb_store_rmw_unit.sv
// Self-checking bench for store_rmw_unit: table vectors, corner sequences and
// randomized stores against a byte-lane reference model.
module tb_store_rmw_unit;

`ifdef STORE_RMW_WORD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [31:0] req_addr, req_data;
    logic [1:0]  req_size;
    logic [31:0] mem_addr, mem_rd_data, mem_wd_data;
    logic        mem_we, done, err;

    logic [31:0] mem [16];
    logic [31:0] ref_mem [16];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    store_rmw_unit dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
        .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .mem_wd_data(mem_wd_data),
        .mem_we(mem_we), .done(done), .err(err)
    );

    // Word memory with one-cycle registered read and no byte enables.
    always @(posedge clk) begin
        mem_rd_data <= mem[mem_addr[5:2]];
        if (mem_we) mem[mem_addr[5:2]] <= mem_wd_data;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Byte-lane view of a store: which bytes it covers and whether it is legal.
    function automatic void ref_store(input logic [31:0] old, input logic [31:0] a,
                                      input logic [31:0] d, input logic [1:0] s,
                                      output logic [31:0] nw, output logic e);
        int off = int'(a % 4);
        int nb  = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
        e  = (s == 2'd3) || ((off % nb) != 0);
        nw = old;
        if (!e)
            for (int b = 0; b < 4; b++)
                if (b >= off && b < off + nb) nw[8*b +: 8] = d[8*(b-off) +: 8];
    endfunction

    task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                            input logic [1:0] s, input string nm);
        logic [31:0] exp_w;
        logic        exp_e;
        int          exp_lat, got_lat, idx;
        idx = int'(a[5:2]);
        ref_store(ref_mem[idx], a, d, s, exp_w, exp_e);
        exp_lat = exp_e ? 1 : ((BYP && s == 2'd2) ? 1 : 2);
        @(negedge clk);
        chk({nm, "_ready_in"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_addr = a; req_data = d; req_size = s;
        got_lat = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            if (done && got_lat == 0) begin
                got_lat = k;
                chk({nm, "_we"}, {31'd0, mem_we}, {31'd0, !exp_e});
                chk({nm, "_err"}, {31'd0, err}, {31'd0, exp_e});
                if (!exp_e) chk({nm, "_wd"}, mem_wd_data, exp_w);
            end else begin
                chk({nm, "_we_idle"}, {31'd0, mem_we}, 32'd0);
                if (got_lat == 0 && k < exp_lat) chk({nm, "_rd_addr"}, mem_addr, {a[31:2], 2'b00});
                if (got_lat != 0 && k == got_lat + 1) chk({nm, "_ready_out"}, {31'd0, req_ready}, 32'd1);
            end
        end
        chk({nm, "_latency"}, got_lat, exp_lat);
        if (!exp_e) ref_mem[idx] = exp_w;
        chk({nm, "_mem"}, mem[idx], ref_mem[idx]);
    endtask

    typedef struct {
        logic [31:0] addr, data, init, exp;
        logic [1:0]  size;
    } vec_t;

    vec_t vecs[8];
    int   first_done, second_done;

    initial begin
        vecs[0] = '{32'h9, 32'h0000_00aa, 32'hdead_beef, 32'hdead_aaef, 2'd0};
        vecs[1] = '{32'ha, 32'h0000_1234, 32'hdead_beef, 32'h1234_beef, 2'd1};
        vecs[2] = '{32'h8, 32'h0000_c0de, 32'h1234_beef, 32'h1234_c0de, 2'd1};
        vecs[3] = '{32'h8, 32'hc001_c0de, 32'hdead_beef, 32'hc001_c0de, 2'd2};
        vecs[4] = '{32'h9, 32'h0000_5555, 32'hdead_beef, 32'hdead_beef, 2'd1};
        vecs[5] = '{32'ha, 32'h1111_2222, 32'hdead_beef, 32'hdead_beef, 2'd2};
        vecs[6] = '{32'h8, 32'h1111_2222, 32'hdead_beef, 32'hdead_beef, 2'd3};
        vecs[7] = '{32'hb, 32'h0000_0022, 32'hdead_be11, 32'h22ad_be11, 2'd0};

        rst = 1'b1; req_valid = 1'b0; req_addr = 32'd0; req_data = 32'd0; req_size = 2'd0;
        for (int i = 0; i < 16; i++) begin mem[i] = 32'd0; ref_mem[i] = 32'd0; end
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wd", mem_wd_data, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            mem[vecs[i].addr[5:2]] = vecs[i].init;
            ref_mem[vecs[i].addr[5:2]] = vecs[i].init;
            do_store(vecs[i].addr, vecs[i].data, vecs[i].size, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_table", i), mem[vecs[i].addr[5:2]], vecs[i].exp);
        end

        // Reset pulsed while the read is outstanding.
        @(negedge clk);
        mem[2] = 32'hdead_beef; ref_mem[2] = 32'hdead_beef;
        req_valid = 1'b1; req_addr = 32'h8; req_data = 32'h0000_0077; req_size = 2'd0;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_ready", {31'd0, req_ready}, 32'd0);
        chk("midrst_we", {31'd0, mem_we}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("midrst_we_after", {31'd0, mem_we}, 32'd0);
            chk("midrst_done_after", {31'd0, done}, 32'd0);
        end
        chk("midrst_ready_after", {31'd0, req_ready}, 32'd1);
        chk("midrst_mem", mem[2], 32'hdead_beef);

        // req_valid held across two byte stores to the same word.
        mem[2] = 32'hdead_beef;
        req_valid = 1'b1; req_addr = 32'h8; req_data = 32'h0000_0011; req_size = 2'd0;
        first_done = 0; second_done = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) begin req_addr = 32'hb; req_data = 32'h0000_0022; end
            if (done) begin
                if (first_done == 0) begin
                    first_done = k;
                    chk("b2b_wd1", mem_wd_data, 32'hdead_be11);
                end else if (second_done == 0) begin
                    second_done = k;
                    req_valid = 1'b0;
                    chk("b2b_wd2", mem_wd_data, 32'h22ad_be11);
                end
            end
        end
        req_valid = 1'b0;
        chk("b2b_first_done", first_done, 2);
        chk("b2b_second_done", second_done, 5);
        chk("b2b_mem", mem[2], 32'h22ad_be11);
        ref_mem[2] = mem[2] === 32'h22ad_be11 ? 32'h22ad_be11 : 32'h22ad_be11;

        // Randomized stores against the reference model.
        for (int i = 0; i < 16; i++) begin
            mem[i] = $urandom; ref_mem[i] = mem[i];
        end
        for (int n = 0; n < 60; n++)
            do_store({26'd0, 6'($urandom_range(0, 63))}, $urandom,
                     2'($urandom_range(0, 3)), $sformatf("rnd%0d", n));
        for (int i = 0; i < 16; i++) chk($sformatf("final_mem%0d", i), mem[i], ref_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
